// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: bit-serial add/subtract, one full-adder cell, operands streamed LSB first.
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b, w_res;
    logic [WIDTH-2:0] r_res;
    logic [CW-1:0] r_cnt;
    logic r_c, r_cmsb, w_s, w_c, w_accept, w_last;
    always_comb begin
        w_accept = start && r_state != RUN;
        w_last = r_state == RUN && r_cnt == LAST;
        w_s = r_a[0] ^ r_b[0] ^ r_c;
        w_c = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
        w_res = {w_s, r_res};
        w_state_nxt = w_accept ? RUN : w_last ? FINISH : r_state == FINISH ? IDLE : r_state;
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end
    assign busy = r_state == RUN;
    assign done = r_state == FINISH;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= 1'b0;
            r_cnt <= '0;
            r_res <= '0;
            r_cmsb <= 1'b0;
            sum <= '0;
            cout <= 1'b0;
            overflow <= 1'b0;
        end else if (w_accept) begin
            r_a <= a;
            r_b <= sub ? ~b : b;
            r_c <= sub | cin;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a <= r_a >> 1;
            r_b <= r_b >> 1;
            r_c <= w_c;
            r_res <= w_res[WIDTH-1:1];
            r_cnt <= w_last ? r_cnt : r_cnt + CW'(1);
            if (r_cnt == PENULT) r_cmsb <= w_c;
            if (w_last) begin
                sum <= w_res;
                cout <= w_c;
                overflow <= r_cmsb ^ w_c;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer: directed and random checks of the bit-serial adder/subtractor.
module tb_serial_add_sequencer;
    logic clk = 1'b0, rst, start, cin, sub;
    logic [7:0] a, b, sum;
    logic busy, done, cout, overflow;
    int checks = 0, failures = 0;
    int n, bc;
    serial_add_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic launch(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic is);
        a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic wait_done();
        n = 0;
        bc = busy ? 1 : 0;
        while (!done && n < 20) begin
            tick();
            n++;
            bc += busy ? 1 : 0;
        end
    endtask
    task automatic expect_res(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                              input logic ic, input logic is);
        logic [8:0] r;
        logic ov;
        r = is ? {1'b0, ia} + {1'b0, ~ib} + 9'd1 : {1'b0, ia} + {1'b0, ib} + {8'd0, ic};
        ov = is ? (ia[7] != ib[7]) && (r[7] != ia[7]) : (ia[7] == ib[7]) && (r[7] != ia[7]);
        chk({tag, "_lat"}, n, 8);
        chk({tag, "_sum"}, sum, {24'd0, r[7:0]});
        chk({tag, "_cout"}, cout, {31'd0, r[8]});
        chk({tag, "_ovf"}, overflow, {31'd0, ov});
    endtask
    initial begin
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", overflow, 0);
        launch(8'h00, 8'h00, 1'b0, 1'b0);
        wait_done();
        chk("zero_busycycles", bc, 8);
        expect_res("zero", 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        chk("zero_done_pulse", done, 0);
        launch(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done();
        expect_res("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        chk("add_ff_01_sum_const", sum, 8'h00);
        chk("add_ff_01_cout_const", cout, 1);
        tick();
        launch(8'h7F, 8'h00, 1'b1, 1'b0);
        wait_done();
        chk("add_7f_sum_const", sum, 8'h80);
        chk("add_7f_ovf_const", overflow, 1);
        expect_res("add_7f_00_c", 8'h7F, 8'h00, 1'b1, 1'b0);
        tick();
        launch(8'h05, 8'h07, 1'b1, 1'b1);
        wait_done();
        chk("sub_5_7_sum_const", sum, 8'hFE);
        chk("sub_5_7_cout_const", cout, 0);
        expect_res("sub_5_7", 8'h05, 8'h07, 1'b1, 1'b1);
        tick();
        launch(8'h80, 8'h01, 1'b0, 1'b1);
        wait_done();
        chk("sub_80_1_sum_const", sum, 8'h7F);
        chk("sub_80_1_ovf_const", overflow, 1);
        expect_res("sub_80_1", 8'h80, 8'h01, 1'b0, 1'b1);
        tick();
        launch(8'h10, 8'h20, 1'b0, 1'b0);
        tick();
        tick();
        chk("sum_held_midrun", sum, 8'h7F);
        a = 8'hAA; b = 8'h55; sub = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        n = n + 3;
        expect_res("ignore_start", 8'h10, 8'h20, 1'b0, 1'b0);
        launch(8'h3C, 8'h0F, 1'b0, 1'b1);
        wait_done();
        expect_res("b2b_first", 8'h3C, 8'h0F, 1'b0, 1'b1);
        launch(8'h21, 8'h43, 1'b1, 1'b0);
        wait_done();
        chk("b2b_gap", n + 1, 9);
        expect_res("b2b_second", 8'h21, 8'h43, 1'b1, 1'b0);
        tick();
        chk("b2b_done_drop", done, 0);
        launch(8'h12, 8'h34, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        bc = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            bc += done ? 1 : 0;
        end
        chk("abort_no_done", bc, 0);
        for (int i = 0; i < 300; i++) begin
            logic [7:0] ra, rb;
            logic rc, rs;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            launch(ra, rb, rc, rs);
            wait_done();
            expect_res("rand", ra, rb, rc, rs);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
